mem_stage_sram_ctrl: RTL and testbench

- Sequences the MEM stage's data-memory access against an external 16-bit asynchronous SRAM.
- Takes memRead/memWrite, ALUResult (address) and reg2Val (store data) from the EXE->MEM pipeline register.
- Performs each 32-bit access as two 16-bit SRAM cycles with programmable wait states.
- Holds stall high so the pipeline freezes until the access completes.

---
 rtl/mem_stage_sram_ctrl_if.sv | 28 ++
 rtl/mem_stage_sram_ctrl.sv | 116 +++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side request/response and SRAM pad signals of the MEM-stage SRAM controller.
interface mem_stage_sram_ctrl_if #(
  parameter int SRAM_ADDR_WIDTH = 18
);
  logic                       memRead;
  logic                       memWrite;
  logic [31:0]                address;
  logic [31:0]                writeData;
  logic [31:0]                readData;
  logic                       ready;
  logic                       stall;
  logic [SRAM_ADDR_WIDTH-1:0] sramAddress;
  logic [15:0]                sramDQOut;
  logic [15:0]                sramDQIn;
  logic                       sramDQOe;
  logic                       sramWE_N;
  logic                       sramOE_N;

  modport slave (
    input  memRead, memWrite, address, writeData, sramDQIn,
    output readData, ready, stall, sramAddress, sramDQOut, sramDQOe, sramWE_N, sramOE_N
  );

  modport master (
    output memRead, memWrite, address, writeData, sramDQIn,
    input  readData, ready, stall, sramAddress, sramDQOut, sramDQOe, sramWE_N, sramOE_N
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory sequencer: each 32-bit load/store becomes two 16-bit
// accesses to an asynchronous SRAM, with the pipeline stalled until completion.
module mem_stage_sram_ctrl #(
  parameter int          SRAM_ADDR_WIDTH = 18,
  parameter int          WAIT_CYCLES     = 2,
  parameter logic [31:0] MEM_BASE        = 32'd1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_stage_sram_ctrl_if.slave bus
);
  localparam int         IDX_W    = SRAM_ADDR_WIDTH - 1;
  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             request_s;
  logic             last_s;
  logic             in_access_s;
  logic [31:0]      offset_s;
  logic             unused_offset_s;

  assign request_s       = bus.memRead | bus.memWrite;
  assign offset_s        = bus.address - MEM_BASE;
  // Byte-lane bits and word-index bits beyond the SRAM are deliberately dropped.
  assign unused_offset_s = ^{offset_s[31:SRAM_ADDR_WIDTH+1], offset_s[1:0]};
  assign last_s          = (cnt_q == LAST_CNT);
  assign in_access_s     = (state_q == LOW) || (state_q == HIGH);

  // State, wait counter and latched request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      write_q <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state sequencing and load-data capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (request_s) begin
          write_d = bus.memWrite;
          idx_d   = offset_s[SRAM_ADDR_WIDTH:2];
          wdata_d = bus.writeData;
          cnt_d   = 3'd0;
          state_d = LOW;
        end else begin
          state_d = IDLE;
        end
      end
      LOW: begin
        if (last_s) begin
          cnt_d   = 3'd0;
          state_d = HIGH;
          rdata_d[15:0] = write_q ? rdata_q[15:0] : bus.sramDQIn;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HIGH: begin
        if (last_s) begin
          cnt_d   = 3'd0;
          state_d = DONE;
          rdata_d[31:16] = write_q ? rdata_q[31:16] : bus.sramDQIn;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pipeline handshake and SRAM pins decoded from the registered state;
  // the last cycle of each half holds address/data with WE_N released.
  assign bus.readData    = rdata_q;
  assign bus.ready       = (state_q == DONE);
  assign bus.stall       = ((state_q == IDLE) && request_s) || in_access_s;
  assign bus.sramAddress = in_access_s ? {idx_q, (state_q == HIGH)} : {SRAM_ADDR_WIDTH{1'b0}};
  assign bus.sramDQOut   = (state_q == LOW)  ? wdata_q[15:0]  :
                           (state_q == HIGH) ? wdata_q[31:16] : 16'h0000;
  assign bus.sramDQOe    = in_access_s && write_q;
  assign bus.sramWE_N    = !(in_access_s && write_q && (cnt_q < LAST_CNT));
  assign bus.sramOE_N    = !(in_access_s && !write_q);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl: randomized loads/stores against a
// word-level reference memory, with a behavioural SRAM on the pads.
module tb_mem_stage_sram_ctrl;
  localparam int AW       = 18;
  localparam int WAITC    = 2;
  localparam int HALF_CYC = WAITC + 1;

  typedef struct {
    bit          is_write;
    int unsigned word;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stage_sram_ctrl_if #(.SRAM_ADDR_WIDTH(AW)) bus ();

  mem_stage_sram_ctrl #(
    .SRAM_ADDR_WIDTH(AW),
    .WAIT_CYCLES    (WAITC),
    .MEM_BASE       (32'd1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_load = 32'd0;
  logic [15:0] sram_mem [0:(1<<AW)-1];
  int          stall_cnt = 0;
  int          we_cnt = 0;
  int          oe_cnt = 0;

  function automatic logic [15:0] pat(input int unsigned h);
    return h[15:0] ^ 16'hA5A5;
  endfunction

  function automatic int unsigned widx(input logic [31:0] addr);
    return ((addr - 32'd1024) >> 2) & 32'h0001_FFFF;
  endfunction

  function automatic logic [31:0] ref_read(input int unsigned w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return {pat(2*w + 1), pat(2*w)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event not expected at %0t", name, $time);
  endtask

  // Asynchronous SRAM: preset contents, writes committed mid-cycle while WE_N is low
  assign bus.sramDQIn = bus.sramOE_N ? 16'h0000 : sram_mem[bus.sramAddress];
  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = pat(i);
    forever begin
      @(negedge clk);
      if (rst && !bus.sramWE_N && bus.sramDQOe) sram_mem[bus.sramAddress] = bus.sramDQOut;
    end
  end

  // Monitor: per-cycle pin checks against queue head, full compare on ready
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_cnt = 0; we_cnt = 0; oe_cnt = 0;
      end else begin
        if (bus.stall) stall_cnt++;
        if (!bus.sramWE_N || !bus.sramOE_N) begin
          if (!bus.sramWE_N) we_cnt++;
          if (!bus.sramOE_N) oe_cnt++;
          if (exp_q.size() == 0) begin
            note_fail("unexpected_sram_access");
          end else begin
            e = exp_q[0];
            check("sram_word_addr", 32'(bus.sramAddress[AW-1:1]), e.word);
            if (!bus.sramWE_N) begin
              check("sram_dq_oe", 32'(bus.sramDQOe), 32'd1);
              check("sram_wdata", 32'(bus.sramDQOut),
                    bus.sramAddress[0] ? 32'(e.wdata[31:16]) : 32'(e.wdata[15:0]));
            end
          end
        end
        if (bus.ready) begin
          if (exp_q.size() == 0) begin
            note_fail("unexpected_ready");
          end else begin
            e = exp_q.pop_front();
            check("readData", bus.readData, e.rdata);
            check("stall_cycles", 32'(stall_cnt), 32'(2*HALF_CYC + 1));
            check("we_low_cycles", 32'(we_cnt), e.is_write ? 32'(2*WAITC) : 32'd0);
            check("oe_low_cycles", 32'(oe_cnt), e.is_write ? 32'd0 : 32'(2*HALF_CYC));
          end
          stall_cnt = 0; we_cnt = 0; oe_cnt = 0;
        end
      end
    end
  end

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input bit b2b, input bit mutate);
    exp_t e;
    int   k;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    e.is_write = wr;
    e.word     = widx(addr);
    e.wdata    = wd;
    if (wr) ref_mem[e.word] = wd;
    else    last_load = ref_read(e.word);
    e.rdata = last_load;
    exp_q.push_back(e);
    bus.memRead = rd; bus.memWrite = wr; bus.address = addr; bus.writeData = wd;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (k == (b2b ? 2 : 1)) begin
        bus.memRead = 1'b0; bus.memWrite = 1'b0;
        if (mutate) begin
          bus.address = 32'd2000; bus.writeData = ~wd;
        end
      end
    end while (!bus.ready && k < 40);
    if (!bus.ready) begin
      note_fail("ready_timeout");
      finish_run();
    end
    check("latency", 32'(k), b2b ? 32'd8 : 32'd7);
  endtask

  initial begin
    exp_t e;
    bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.address = 32'd0; bus.writeData = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_readData", bus.readData, 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_sramAddress", 32'(bus.sramAddress), 32'd0);
    check("rst_sramDQOut", 32'(bus.sramDQOut), 32'd0);
    check("rst_sramDQOe", 32'(bus.sramDQOe), 32'd0);
    check("rst_sramWE_N", 32'(bus.sramWE_N), 32'd1);
    check("rst_sramOE_N", 32'(bus.sramOE_N), 32'd1);
    rst = 1'b1;

    do_access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 1'b0);

    // Reset asserted in the middle of the high half of a store
    @(posedge clk); #1;
    e.is_write = 1'b1; e.word = widx(32'd5024); e.wdata = 32'h0BAD_F00D; e.rdata = last_load;
    exp_q.push_back(e);
    bus.memWrite = 1'b1; bus.address = 32'd5024; bus.writeData = 32'h0BAD_F00D;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.memWrite = 1'b0;
    end
    check("pre_rst_we_low", 32'(bus.sramWE_N), 32'd0);
    check("pre_rst_high_half", 32'(bus.sramAddress[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_sramWE_N", 32'(bus.sramWE_N), 32'd1);
    check("arst_sramDQOe", 32'(bus.sramDQOe), 32'd0);
    check("arst_stall", 32'(bus.stall), 32'd0);
    check("arst_readData", bus.readData, 32'd0);
    check("arst_ready", 32'(bus.ready), 32'd0);
    exp_q.delete();
    ref_mem[e.word] = e.wdata;
    last_load = 32'd0;
    @(posedge clk); #1;
    rst = 1'b1;

    do_access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1028, 32'd0,         1'b1, 1'b0);
    do_access(1'b0, 1'b1, 32'd1029, 32'h1234_5678, 1'b0, 1'b1);
    do_access(1'b1, 1'b0, 32'd1030, 32'd0,         1'b0, 1'b1);
    do_access(1'b1, 1'b1, 32'd1024, 32'hCAFE_F00D, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 32'd1024, 32'd0,         1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'd1024 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      do_access(op <= 3 || op == 7, op >= 4, a, $urandom,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    finish_run();
  end
endmodule
